// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage load/store path.
// Lane logic assumes a 32-bit data word (four byte lanes).
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_RESP = 2'b01,
        DONE      = 2'b10
    } mau_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // The reserved size encoding falls into the default arm and behaves as a word.
    function automatic logic [3:0] byte_enable(input mem_size_e size, input logic [1:0] offset);
        case (size)
            BYTE:    return BE_BYTE << offset;
            HALF:    return BE_HALF << {offset[1], 1'b0};
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input mem_size_e size, input logic [31:0] wd);
        case (size)
            BYTE:    return {4{wd[7:0]}};
            HALF:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bus between the load/store unit (master)
// and the data cache (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load data lane selection and sign/zero extension. Purely combinational so
// it can be shared by cached and uncached read paths.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        result    = rdata;
        case (size)
            BYTE:    result = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            HALF:    result = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: issues data-cache requests, stalls on misses and
// registers extended load data into the M->W boundary for writeback.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mem_read_m_i,
    input  logic               mem_write_m_i,
    input  logic [1:0]         mem_size_m_i,
    input  logic               mem_unsigned_m_i,
    input  logic [ADDR_W-1:0]  addr_m_i,
    input  logic [DATA_W-1:0]  write_data_m_i,
    input  logic               hold_i,
    output logic               stall_m_o,
    output logic               misaligned_m_o,
    mem_access_unit_if.master  dc,
    output logic [DATA_W-1:0]  read_data_w_o
);

    mau_state_e        state, state_next;
    mem_size_e         size;
    logic              valid_op;
    logic              is_load;
    logic              is_store;
    logic              align_err;
    logic              access;
    logic              done_now;
    logic              load_done;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] data_buf;

    assign size     = mem_size_e'(mem_size_m_i);
    assign valid_op = mem_read_m_i | mem_write_m_i;
    assign is_load  = mem_read_m_i;
    assign is_store = mem_write_m_i & ~mem_read_m_i;

    always_comb begin
        align_err = 1'b0;
        case (size)
            BYTE:    align_err = 1'b0;
            HALF:    align_err = addr_m_i[0];
            default: align_err = |addr_m_i[1:0];
        endcase
    end

    assign misaligned_m_o = valid_op & align_err;
    assign access         = valid_op & ~align_err;

    assign dc.we    = is_store;
    assign dc.addr  = {addr_m_i[ADDR_W-1:2], 2'b00};
    assign dc.be    = byte_enable(size, addr_m_i[1:0]);
    assign dc.wdata = lane_replicate(size, write_data_m_i);

    load_extend u_load_extend (
        .rdata       (dc.rdata),
        .addr_lo     (addr_m_i[1:0]),
        .size        (size),
        .is_unsigned (mem_unsigned_m_i),
        .result      (ext_data)
    );

    // Requests are only driven from IDLE; WAIT_RESP and DONE never re-issue.
    always_comb begin
        state_next = state;
        done_now   = 1'b0;
        stall_m_o  = 1'b0;
        dc.req     = 1'b0;
        case (state)
            IDLE: begin
                dc.req    = access;
                done_now  = access & dc.ready & (is_store | dc.rvalid);
                stall_m_o = access & ~done_now;
                if (access & is_load & dc.ready & ~dc.rvalid) begin
                    state_next = WAIT_RESP;
                end else if (done_now & hold_i) begin
                    state_next = DONE;
                end
            end
            WAIT_RESP: begin
                done_now  = dc.rvalid;
                stall_m_o = ~dc.rvalid;
                if (dc.rvalid) begin
                    state_next = hold_i ? DONE : IDLE;
                end
            end
            DONE: begin
                if (!hold_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_done = done_now & is_load;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Parks the completed result while the M->W register is frozen; a store parks zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_buf <= '0;
        end else if (done_now && hold_i) begin
            data_buf <= is_load ? ext_data : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            read_data_w_o <= '0;
        end else if (!hold_i && !stall_m_o) begin
            if (load_done) begin
                read_data_w_o <= ext_data;
            end else if (state == DONE) begin
                read_data_w_o <= data_buf;
            end else begin
                read_data_w_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: hits, misses, store
// backpressure, completion under hold, misalignment and reset mid-miss.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_read_m_i;
    logic        mem_write_m_i;
    logic [1:0]  mem_size_m_i;
    logic        mem_unsigned_m_i;
    logic [31:0] addr_m_i;
    logic [31:0] write_data_m_i;
    logic        hold_i;
    logic        stall_m_o;
    logic        misaligned_m_o;
    logic [31:0] read_data_w_o;

    int passed = 0;
    int total  = 0;
    int acc_cnt = 0;
    int acc_start;

    mem_access_unit_if dc_bus ();

    mem_access_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mem_read_m_i     (mem_read_m_i),
        .mem_write_m_i    (mem_write_m_i),
        .mem_size_m_i     (mem_size_m_i),
        .mem_unsigned_m_i (mem_unsigned_m_i),
        .addr_m_i         (addr_m_i),
        .write_data_m_i   (write_data_m_i),
        .hold_i           (hold_i),
        .stall_m_o        (stall_m_o),
        .misaligned_m_o   (misaligned_m_o),
        .dc               (dc_bus),
        .read_data_w_o    (read_data_w_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (dc_bus.req && dc_bus.ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_m_i     = 1'b0;
        mem_write_m_i    = 1'b0;
        mem_size_m_i     = 2'b00;
        mem_unsigned_m_i = 1'b0;
        addr_m_i         = 32'h0;
        write_data_m_i   = 32'h0;
        hold_i           = 1'b0;
        dc_bus.ready     = 1'b0;
        dc_bus.rvalid    = 1'b0;
        dc_bus.rdata     = 32'h0;
    endtask

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("reset_rdata", read_data_w_o, 32'h0);
        check("reset_stall", stall_m_o, 1'b0);
        check("reset_req", dc_bus.req, 1'b0);
        rst_i = 1'b1;
        tick();

        // Word load hit
        mem_read_m_i = 1'b1; mem_size_m_i = 2'b10; addr_m_i = 32'h100;
        dc_bus.ready = 1'b1; dc_bus.rvalid = 1'b1; dc_bus.rdata = 32'hDEADBEEF;
        #1;
        check("lw_hit_stall", stall_m_o, 1'b0);
        check("lw_hit_req", dc_bus.req, 1'b1);
        check("lw_hit_be", dc_bus.be, 4'b1111);
        check("lw_hit_we", dc_bus.we, 1'b0);
        check("lw_hit_addr", dc_bus.addr, 32'h100);
        tick();
        check("lw_hit_rdata", read_data_w_o, 32'hDEADBEEF);

        // LB miss at 0x103: three stalled cycles before rvalid
        mem_size_m_i = 2'b00; addr_m_i = 32'h103; dc_bus.rvalid = 1'b0;
        #1;
        check("lb_miss_stall0", stall_m_o, 1'b1);
        check("lb_miss_req", dc_bus.req, 1'b1);
        check("lb_miss_be", dc_bus.be, 4'b1000);
        check("lb_miss_addr", dc_bus.addr, 32'h100);
        tick();
        dc_bus.ready = 1'b0;
        #1;
        check("lb_miss_stall1", stall_m_o, 1'b1);
        check("lb_miss_no_reissue", dc_bus.req, 1'b0);
        check("lb_miss_held_rdata", read_data_w_o, 32'hDEADBEEF);
        tick();
        check("lb_miss_stall2", stall_m_o, 1'b1);
        tick();
        dc_bus.rvalid = 1'b1; dc_bus.rdata = 32'h80112233;
        #1;
        check("lb_miss_release", stall_m_o, 1'b0);
        tick();
        check("lb_rdata", read_data_w_o, 32'hFFFFFF80);

        // Same access as LBU, one wait cycle
        mem_unsigned_m_i = 1'b1; dc_bus.ready = 1'b1; dc_bus.rvalid = 1'b0;
        #1;
        check("lbu_stall", stall_m_o, 1'b1);
        tick();
        dc_bus.ready = 1'b0; dc_bus.rvalid = 1'b1;
        #1;
        check("lbu_release", stall_m_o, 1'b0);
        tick();
        check("lbu_rdata", read_data_w_o, 32'h00000080);

        // SH at 0x102 with two cycles of backpressure
        idle_inputs();
        mem_write_m_i = 1'b1; mem_size_m_i = 2'b01; addr_m_i = 32'h102;
        write_data_m_i = 32'h0000ABCD;
        acc_start = acc_cnt;
        #1;
        check("sh_req", dc_bus.req, 1'b1);
        check("sh_stall0", stall_m_o, 1'b1);
        check("sh_be", dc_bus.be, 4'b1100);
        check("sh_wdata", dc_bus.wdata, 32'hABCDABCD);
        check("sh_we", dc_bus.we, 1'b1);
        tick();
        check("sh_req_held", dc_bus.req, 1'b1);
        check("sh_stall1", stall_m_o, 1'b1);
        check("sh_held_rdata", read_data_w_o, 32'h00000080);
        tick();
        dc_bus.ready = 1'b1;
        #1;
        check("sh_accept_nostall", stall_m_o, 1'b0);
        tick();
        check("sh_rdata_zero", read_data_w_o, 32'h0);
        idle_inputs();
        #1;
        check("sh_one_accept", acc_cnt - acc_start, 32'd1);

        // LH hit at 0x100 completing under two cycles of hold
        read_data_w_o_preload: begin end
        mem_read_m_i = 1'b1; mem_size_m_i = 2'b01; addr_m_i = 32'h100;
        dc_bus.ready = 1'b1; dc_bus.rvalid = 1'b1; dc_bus.rdata = 32'h1234F00D;
        hold_i = 1'b1;
        acc_start = acc_cnt;
        #1;
        check("lh_hold_stall", stall_m_o, 1'b0);
        tick();
        dc_bus.ready = 1'b0; dc_bus.rvalid = 1'b0; dc_bus.rdata = 32'h0;
        #1;
        check("lh_hold_state", 32'(dut.state), 32'(DONE));
        check("lh_hold_no_req", dc_bus.req, 1'b0);
        check("lh_hold_no_stall", stall_m_o, 1'b0);
        check("lh_hold_rdata0", read_data_w_o, 32'h0);
        tick();
        check("lh_hold_rdata1", read_data_w_o, 32'h0);
        check("lh_hold_no_req2", dc_bus.req, 1'b0);
        hold_i = 1'b0;
        tick();
        check("lh_release_rdata", read_data_w_o, 32'hFFFFF00D);
        idle_inputs();
        #1;
        check("lh_one_accept", acc_cnt - acc_start, 32'd1);

        // Misaligned LW at 0x101 and misaligned SH at 0x103
        mem_read_m_i = 1'b1; mem_size_m_i = 2'b10; addr_m_i = 32'h101; dc_bus.ready = 1'b1;
        #1;
        check("lw_mis_flag", misaligned_m_o, 1'b1);
        check("lw_mis_req", dc_bus.req, 1'b0);
        check("lw_mis_stall", stall_m_o, 1'b0);
        tick();
        check("lw_mis_rdata", read_data_w_o, 32'h0);
        mem_read_m_i = 1'b0; mem_write_m_i = 1'b1; mem_size_m_i = 2'b01; addr_m_i = 32'h103;
        #1;
        check("sh_mis_flag", misaligned_m_o, 1'b1);
        check("sh_mis_req", dc_bus.req, 1'b0);

        // SB hit at 0x001
        mem_size_m_i = 2'b00; addr_m_i = 32'h001; write_data_m_i = 32'h1234565A;
        #1;
        check("sb_mis_flag", misaligned_m_o, 1'b0);
        check("sb_be", dc_bus.be, 4'b0010);
        check("sb_wdata", dc_bus.wdata, 32'h5A5A5A5A);
        check("sb_stall", stall_m_o, 1'b0);
        tick();
        idle_inputs();

        // Reset while waiting on a miss
        mem_read_m_i = 1'b1; mem_size_m_i = 2'b10; addr_m_i = 32'h200;
        dc_bus.ready = 1'b1; dc_bus.rvalid = 1'b1; dc_bus.rdata = 32'hCAFEF00D;
        tick();
        check("pre_reset_rdata", read_data_w_o, 32'hCAFEF00D);
        addr_m_i = 32'h104; dc_bus.rvalid = 1'b0;
        tick();
        dc_bus.ready = 1'b0;
        #1;
        check("pre_reset_wait", 32'(dut.state), 32'(WAIT_RESP));
        #2;
        rst_i = 1'b0;
        mem_read_m_i = 1'b0;
        #1;
        check("rst_rdata", read_data_w_o, 32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        tick();
        rst_i = 1'b1;
        dc_bus.rvalid = 1'b1; dc_bus.rdata = 32'h55555555;
        #1;
        check("stray_rvalid_stall", stall_m_o, 1'b0);
        check("stray_rvalid_req", dc_bus.req, 1'b0);
        tick();
        check("stray_rvalid_rdata", read_data_w_o, 32'h0);
        check("stray_rvalid_state", 32'(dut.state), 32'(IDLE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
